// File: rtl/fpmul_job_sequencer_if.sv
// Stream and peripheral-bus signals of the FP-multiplier job sequencer.
// master: the sequencer side; slave: the environment (producer, consumer, peripheral).
interface fpmul_job_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [5:0]  out_flags;
  logic        out_timeout;
  logic [1:0]  bus_a;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [15:0] job_count;

  modport master (
    input  in_valid, in_a, in_b, out_ready, bus_rdata,
    output in_ready, out_valid, out_p, out_flags, out_timeout,
           bus_a, bus_we, bus_wdata, job_count
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, bus_rdata,
    input  in_ready, out_valid, out_p, out_flags, out_timeout,
           bus_a, bus_we, bus_wdata, job_count
  );
endinterface

// File: rtl/fpmul_job_sequencer.sv
// Sequencer: takes one operand pair, programs the FP-multiplier peripheral over
// its 2-bit register bus, polls for done (with timeout), reads back the product
// and flags and hands them out on a valid/ready stream. One job in flight.
// All outputs are registered; bus outputs are loaded with the values of the
// state being entered, so they are valid for the whole cycle of that state.
module fpmul_job_sequencer #(
  parameter int TIMEOUT = 255
) (
  input logic Clk,
  input logic Rst,
  fpmul_job_sequencer_if.master io
);
  localparam logic [1:0]  A_OPA   = 2'd0;
  localparam logic [1:0]  A_OPB   = 2'd1;
  localparam logic [1:0]  A_PROD  = 2'd2;
  localparam logic [1:0]  A_CTL   = 2'd3;
  localparam logic [31:0] START_W = 32'h0001_0000;
  localparam logic [15:0] T_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, START, WAIT, RD_P, OUT} state_t;

  state_t      state;
  logic [31:0] opnd_b;
  logic [15:0] timer;

  // Job FSM with registered stream, bus and counter outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= IDLE;
      opnd_b          <= '0;
      timer           <= '0;
      io.in_ready     <= 1'b1;
      io.out_valid    <= 1'b0;
      io.out_p        <= '0;
      io.out_flags    <= '0;
      io.out_timeout  <= 1'b0;
      io.bus_a        <= A_CTL;
      io.bus_we       <= 1'b0;
      io.bus_wdata    <= '0;
      io.job_count    <= '0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          // A goes straight onto the bus; B is kept for the next cycle.
          opnd_b       <= io.in_b;
          io.in_ready  <= 1'b0;
          io.bus_a     <= A_OPA;
          io.bus_we    <= 1'b1;
          io.bus_wdata <= io.in_a;
          state        <= WR_A;
        end
        WR_A: begin
          io.bus_a     <= A_OPB;
          io.bus_wdata <= opnd_b;
          state        <= WR_B;
        end
        WR_B: begin
          io.bus_a     <= A_CTL;
          io.bus_wdata <= START_W;
          state        <= START;
        end
        START: begin
          timer        <= '0;
          io.bus_a     <= A_CTL;
          io.bus_we    <= 1'b0;
          io.bus_wdata <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (io.bus_rdata[0]) begin
            io.out_flags <= io.bus_rdata[13:8];
            io.bus_a     <= A_PROD;
            state        <= RD_P;
          end else if (timer == T_LAST) begin
            // Abandon the job; the peripheral is left as-is and the next
            // job's start write clears its done bit.
            io.out_p       <= '0;
            io.out_flags   <= '0;
            io.out_timeout <= 1'b1;
            io.out_valid   <= 1'b1;
            state          <= OUT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RD_P: begin
          io.out_p       <= io.bus_rdata;
          io.out_timeout <= 1'b0;
          io.out_valid   <= 1'b1;
          io.bus_a       <= A_CTL;
          state          <= OUT;
        end
        OUT: if (io.out_ready) begin
          io.out_valid <= 1'b0;
          io.in_ready  <= 1'b1;
          io.job_count <= io.job_count + 16'd1;
          state        <= IDLE;
        end
        default: begin
          io.in_ready  <= 1'b1;
          io.out_valid <= 1'b0;
          io.bus_a     <= A_CTL;
          io.bus_we    <= 1'b0;
          io.bus_wdata <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpmul_job_sequencer.sv
// Bench for fpmul_job_sequencer: a behavioural peripheral stub with a per-job
// done delay, a queue-based reference model of bus writes, results and
// latencies, and directed plus random jobs.
module tb_fpmul_job_sequencer;
  localparam int TMO = 8;

  logic Clk, Rst;
  fpmul_job_sequencer_if sif();

  fpmul_job_sequencer #(.TIMEOUT(TMO)) dut (.Clk(Clk), .Rst(Rst), .io(sif));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Simple IEEE single multiply model used by the stub: denormals read as
  // zero, truncating rounding. Returns {flags, product}.
  function automatic logic [37:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] m;
    logic [22:0] fr;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      if ((a[30:23] == 8'd0 && a[22:0] != 0) || (b[30:23] == 8'd0 && b[22:0] != 0))
        return {6'b000011, s, 31'd0};
      return {6'b000001, s, 31'd0};
    end
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {6'b000100, s, 8'hFF, 23'd0};
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin fr = m[46:24]; e++; end
    else fr = m[45:23];
    if (e >= 255) return {6'b100000, s, 8'hFF, 23'd0};
    if (e <= 0)   return {6'b010001, s, 31'd0};
    return {6'b000000, s, 8'(e), fr};
  endfunction

  // ---------------- peripheral stub ----------------
  int          dly_q[$];
  logic [31:0] p_a = '0, p_b = '0;
  logic        p_run = 1'b0;
  int          p_el = 0, p_d = 0;
  logic        p_done;
  logic [37:0] p_res;

  always @(posedge Clk) begin
    if (sif.bus_we && sif.bus_a == 2'd0) p_a <= sif.bus_wdata;
    if (sif.bus_we && sif.bus_a == 2'd1) p_b <= sif.bus_wdata;
    if (sif.bus_we && sif.bus_a == 2'd3 && sif.bus_wdata[16]) begin
      p_run <= 1'b1;
      p_el  <= 1;
      p_d   <= (dly_q.size() != 0) ? dly_q.pop_front() : 0;
    end else if (p_run) p_el <= p_el + 1;
  end

  always_comb begin
    p_done = p_run && (p_d != 0) && (p_el >= p_d);
    p_res  = stub_mul(p_a, p_b);
    case (sif.bus_a)
      2'd0: sif.bus_rdata = p_a;
      2'd1: sif.bus_rdata = p_b;
      2'd2: sif.bus_rdata = p_done ? p_res[31:0] : 32'hDEAD_BEEF;
      default: sif.bus_rdata = {15'h4A3C, p_run, 2'b10,
                                p_done ? p_res[37:32] : 6'h2A, 7'b1010101, p_done};
    endcase
  end

  // ---------------- reference model / monitor ----------------
  typedef struct {logic [31:0] a; logic [31:0] b; int d; int e;} job_t;
  job_t        job_q[$];
  logic [33:0] wr_q[$];
  int          dly_next = 1;
  logic        prev_vld = 1'b0, prev_hs = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [38:0] hold;
  logic [31:0] last_p;
  logic [5:0]  last_f;
  logic        last_to;
  int          last_lat;
  logic        bp = 1'b0, rnd_rdy = 1'b0;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Rst) begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (prev_hs) begin
        exp_cnt++;
        chk("job_count", 64'(sif.job_count), 64'(exp_cnt));
        chk("idle_after_hs", 64'({sif.in_ready, sif.out_valid}), 64'(2'b10));
      end
      if (sif.bus_we) begin
        if (wr_q.size() == 0) chk("unexp_write", 64'({sif.bus_a, sif.bus_wdata}), 64'h0);
        else chk("bus_write", 64'({sif.bus_a, sif.bus_wdata}), 64'(wr_q.pop_front()));
      end
      if (sif.in_valid && sif.in_ready) begin
        job_q.push_back('{sif.in_a, sif.in_b, dly_next, cyc + 1});
        dly_q.push_back(dly_next);
        wr_q.push_back({2'd0, sif.in_a});
        wr_q.push_back({2'd1, sif.in_b});
        wr_q.push_back({2'd3, 32'h0001_0000});
      end
      if (sif.out_valid) begin
        chk("vld_rdy_excl", 64'(sif.in_ready), 64'(0));
        if (!prev_vld) begin
          if (job_q.size() == 0) chk("unexp_out", 64'(sif.out_p), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            job_t        j;
            logic [37:0] r;
            j = job_q.pop_front();
            last_lat = cyc - j.e;
            if (j.d >= 1 && j.d <= TMO) begin
              r = stub_mul(j.a, j.b);
              chk("latency", 64'(last_lat), 64'(4 + j.d));
              chk("out_p", 64'(sif.out_p), 64'(r[31:0]));
              chk("out_flags", 64'(sif.out_flags), 64'(r[37:32]));
              chk("out_timeout", 64'(sif.out_timeout), 64'(0));
            end else begin
              chk("to_latency", 64'(last_lat), 64'(3 + TMO));
              chk("to_p_flags", 64'({sif.out_p, sif.out_flags}), 64'(0));
              chk("to_flag", 64'(sif.out_timeout), 64'(1));
            end
          end
          hold    = {sif.out_p, sif.out_flags, sif.out_timeout};
          last_p  = sif.out_p;
          last_f  = sif.out_flags;
          last_to = sif.out_timeout;
        end else begin
          chk("out_hold", 64'({sif.out_p, sif.out_flags, sif.out_timeout}), 64'(hold));
        end
      end
      prev_vld = sif.out_valid;
      prev_hs  = sif.out_valid && sif.out_ready;
    end
  end

  // Consumer: always ready, randomly ready, or stalled.
  initial begin
    sif.out_ready = 1'b0;
    forever begin
      @(posedge Clk); #1;
      sif.out_ready = bp ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input int d);
    @(posedge Clk); #1;
    sif.in_a = a; sif.in_b = b; dly_next = d; sif.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (sif.in_ready) begin
        @(posedge Clk); #1;
        return;
      end
    end
    chk("accept_timeout", 64'(0), 64'(1));
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    sif.in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (job_q.size() == 0 && !sif.out_valid && sif.in_ready) begin
        @(negedge Clk);
        return;
      end
    end
    chk("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic pulse_reset(input logic [15:0] cnt_after);
    @(posedge Clk); #1;
    Rst = 1'b1;
    sif.in_valid = 1'b0;
    #1;
    chk("rst_bus", 64'({sif.bus_a, sif.bus_we, sif.bus_wdata}), 64'({2'd3, 1'b0, 32'd0}));
    chk("rst_out", 64'({sif.out_valid, sif.out_p, sif.out_flags, sif.out_timeout}), 64'(0));
    chk("rst_cnt", 64'(sif.job_count), 64'(cnt_after));
    job_q.delete(); wr_q.delete(); dly_q.delete();
    exp_cnt = '0;
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 5) == 0) v[30:0] = '0;
    else if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    Rst = 1'b1;
    sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0;
    #1;
    chk("reset_bus", 64'({sif.bus_a, sif.bus_we, sif.bus_wdata}), 64'({2'd3, 1'b0, 32'd0}));
    chk("reset_out", 64'({sif.out_valid, sif.out_p, sif.out_flags, sif.out_timeout}), 64'(0));
    chk("reset_cnt", 64'(sif.job_count), 64'(0));
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("reset_in_ready", 64'(sif.in_ready), 64'(1));

    // basic: 1.0 * 2.0, done after 5 WAIT cycles
    send(32'h3F80_0000, 32'h4000_0000, 5);
    wait_idle();
    chk("basic_p", 64'(last_p), 64'h4000_0000);
    chk("basic_flags", 64'(last_f), 64'(0));
    chk("basic_lat", 64'(last_lat), 64'(9));
    chk("basic_cnt", 64'(sif.job_count), 64'(1));

    // zero operand
    send(32'h0000_0000, 32'h40A0_0000, 3);
    wait_idle();
    chk("zero_p", 64'(last_p), 64'h0);
    chk("zero_flags", 64'(last_f), 64'(6'b000001));

    // back-to-back with in_valid held; operands change while busy
    send(32'h4040_0000, 32'h4080_0000, 1);
    send(32'hC000_0000, 32'h3F00_0000, 2);
    send(32'h7F00_0000, 32'h7F00_0000, 4);
    wait_idle();
    chk("b2b_cnt", 64'(sif.job_count), 64'(5));

    // backpressure for 10 cycles
    bp = 1'b1;
    send(32'h4120_0000, 32'h4130_0000, 2);
    sif.in_valid = 1'b1;
    for (int i = 0; i < 50 && !sif.out_valid; i++) @(negedge Clk);
    chk("bp_valid_seen", 64'(sif.out_valid), 64'(1));
    repeat (10) begin
      @(negedge Clk);
      chk("bp_in_ready", 64'(sif.in_ready), 64'(0));
      chk("bp_valid", 64'(sif.out_valid), 64'(1));
    end
    bp = 1'b0;
    wait_idle();
    chk("bp_cnt", 64'(sif.job_count), 64'(6));

    // timeout (never done), then done exactly on the last poll, then one late
    send(32'h3F80_0000, 32'h3F80_0000, 0);
    wait_idle();
    chk("to_lat", 64'(last_lat), 64'(3 + TMO));
    chk("to_flag_dir", 64'(last_to), 64'(1));
    chk("to_cnt", 64'(sif.job_count), 64'(7));
    send(32'h3FC0_0000, 32'h4000_0000, TMO);
    wait_idle();
    chk("edge_p", 64'(last_p), 64'h4040_0000);
    chk("edge_to", 64'(last_to), 64'(0));
    send(32'h3FC0_0000, 32'h4000_0000, TMO + 1);
    wait_idle();
    chk("late_to", 64'(last_to), 64'(1));

    // reset in the middle of WAIT, then a normal job
    send(32'h4000_0000, 32'h4000_0000, 0);
    sif.in_valid = 1'b0;
    repeat (5) @(posedge Clk);
    pulse_reset(16'd0);
    send(32'h4000_0000, 32'h4040_0000, 3);
    wait_idle();
    chk("post_rst_p", 64'(last_p), 64'h40C0_0000);
    chk("post_rst_cnt", 64'(sif.job_count), 64'(1));

    // random jobs, random consumer
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send(rnd_fp(), rnd_fp(), $urandom_range(0, TMO + 2));
      if ($urandom_range(0, 2) == 0) sif.in_valid = 1'b0;
    end
    wait_idle();
    chk("rand_cnt", 64'(sif.job_count), 64'(41));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
